// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl: edge-triggered interrupt collector, fixed-priority arbiter and
// assert/acknowledge/EOI sequencer for the pacoblaze3 interrupt input.
// Firmware accesses it through the core port_id/in_port/out_port I/O space.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | irq low, waiting for GIE and an enabled pending source
// S_ASSERT  | irq high, waiting for interrupt_ack from the core
// S_SERVICE | handler running, irq low until firmware writes EOI
module pb_irq_ctrl #(
    parameter int          NSRC = 8,
    parameter logic [7:0]  BASE = 8'h10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [7:0]      port_id,
    input  logic [7:0]      out_port,
    input  logic            write_strobe,
    input  logic            read_strobe,
    output logic [7:0]      in_port,
    output logic            irq,
    input  logic            iak
);

    localparam logic [7:0] A_PEND  = BASE;
    localparam logic [7:0] A_MASK  = BASE + 8'd1;
    localparam logic [7:0] A_CLEAR = BASE + 8'd2;
    localparam logic [7:0] A_VEC   = BASE + 8'd3;
    localparam logic [7:0] A_CTRL  = BASE + 8'd4;
    localparam logic [7:0] A_EOI   = BASE + 8'd5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;
    logic [NSRC-1:0] r_sync3;
    logic [2:0]      r_vld;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic            r_gie;
    logic [7:0]      r_in_port;
    logic            r_irq;
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_irq_nxt;

    logic [NSRC-1:0] w_edge;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_active;
    logic            w_any;
    logic [2:0]      w_idx;
    logic [7:0]      w_pend8;
    logic [7:0]      w_mask8;
    logic [7:0]      w_rdata;
    logic            w_wr_mask;
    logic            w_wr_clear;
    logic            w_wr_ctrl;
    logic            w_wr_eoi;
    logic            w_unused;

    // read_strobe is not needed: reads have no side effects
    assign w_unused = read_strobe ^ (^out_port);

    assign w_wr_mask  = write_strobe && (port_id == A_MASK);
    assign w_wr_clear = write_strobe && (port_id == A_CLEAR);
    assign w_wr_ctrl  = write_strobe && (port_id == A_CTRL);
    assign w_wr_eoi   = write_strobe && (port_id == A_EOI);

    // Edge detection stays disarmed until the synchronizer holds real samples,
    // so a source already high when reset releases is not seen as an edge.
    assign w_edge   = r_sync2 & ~r_sync3 & {NSRC{r_vld[2]}};
    assign w_clr    = w_wr_clear ? out_port[NSRC-1:0] : '0;
    assign w_active = r_pending & r_mask;
    assign w_any    = |w_active;

    // Synchronizer, edge-detect history and its arming shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_vld   <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_vld   <= {r_vld[1:0], 1'b1};
        end
    end

    // Pending, mask and GIE registers; a new edge beats a CLEAR on the same bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_gie     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (w_wr_mask) r_mask <= out_port[NSRC-1:0];
            if (w_wr_ctrl) r_gie  <= out_port[0];
        end
    end

    // Fixed priority: lowest active index wins
    always_comb begin
        w_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) w_idx = 3'(i);
        end
    end

    // Read-data decode, zero-extended to the 8-bit bus
    always_comb begin
        w_pend8 = 8'h00;
        w_mask8 = 8'h00;
        w_pend8[NSRC-1:0] = r_pending;
        w_mask8[NSRC-1:0] = r_mask;
        case (port_id)
            A_PEND:  w_rdata = w_pend8;
            A_MASK:  w_rdata = w_mask8;
            A_VEC:   w_rdata = {w_any, 4'b0000, w_idx};
            A_CTRL:  w_rdata = {7'b0000000, r_gie};
            default: w_rdata = 8'h00;
        endcase
    end

    // in_port is re-registered every cycle from the current port_id
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_in_port <= 8'h00;
        else      r_in_port <= w_rdata;
    end

    // FSM state register; irq is registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // FSM next-state logic; iak takes precedence over withdrawal in ASSERT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (r_gie && w_any)            w_state_nxt = S_ASSERT;
            S_ASSERT:  if (iak)                       w_state_nxt = S_SERVICE;
                       else if (!r_gie || !w_any)     w_state_nxt = S_IDLE;
            S_SERVICE: if (w_wr_eoi)                  w_state_nxt = S_IDLE;
            default:                                  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic: irq is high exactly while in ASSERT
    always_comb begin
        w_irq_nxt = (w_state_nxt == S_ASSERT);
    end

    assign in_port = r_in_port;
    assign irq     = r_irq;

endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Self-checking bench for pb_irq_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_pb_irq_ctrl;

    localparam int         NSRC = 8;
    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] A_PEND  = BASE;
    localparam logic [7:0] A_MASK  = BASE + 8'd1;
    localparam logic [7:0] A_CLEAR = BASE + 8'd2;
    localparam logic [7:0] A_VEC   = BASE + 8'd3;
    localparam logic [7:0] A_CTRL  = BASE + 8'd4;
    localparam logic [7:0] A_EOI   = BASE + 8'd5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NSRC-1:0] src = '0;
    logic [7:0]      port_id = 8'h00;
    logic [7:0]      out_port = 8'h00;
    logic            write_strobe = 1'b0;
    logic            read_strobe = 1'b0;
    logic [7:0]      in_port;
    logic            irq;
    logic            iak = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    pb_irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .src          (src),
        .port_id      (port_id),
        .out_port     (out_port),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .irq          (irq),
        .iak          (iak)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_pend, m_mask, m_in;
    logic       m_gie, m_irq, m_svc;
    logic [7:0] hist[$];
    logic [7:0] m_set, m_clr, m_act;
    logic       m_eoi;

    function automatic logic [7:0] vec_of(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) if (a[i]) r = 8'h80 | 8'(i);
        return r;
    endfunction

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        if (a == A_PEND) return m_pend;
        if (a == A_MASK) return m_mask;
        if (a == A_VEC)  return vec_of(m_pend & m_mask);
        if (a == A_CTRL) return {7'd0, m_gie};
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = 0; m_mask = 0; m_gie = 0; m_irq = 0; m_svc = 0; m_in = 0;
            hist.delete();
        end else begin
            // hist[j] = src sampled j edges ago; an edge needs 4 samples since reset
            hist.push_front(src);
            if (hist.size() > 4) void'(hist.pop_back());
            m_set = (hist.size() == 4) ? (hist[2] & ~hist[3]) : 8'h00;
            m_act = m_pend & m_mask;
            m_in  = rd_model(port_id);
            m_eoi = write_strobe && (port_id == A_EOI);
            if (m_svc) begin
                if (m_eoi) m_svc = 0;
                m_irq = 0;
            end else if (m_irq && iak) begin
                m_svc = 1;
                m_irq = 0;
            end else begin
                m_irq = m_gie && (m_act != 0);
            end
            m_clr = 8'h00;
            if (write_strobe) begin
                if (port_id == A_MASK)  m_mask = out_port;
                if (port_id == A_CTRL)  m_gie  = out_port[0];
                if (port_id == A_CLEAR) m_clr  = out_port;
            end
            m_pend = (m_pend & ~m_clr) | m_set;
        end
    end

    // Every-cycle comparison of the outputs against the model
    always @(posedge clk or negedge rst) begin
        #1;
        n_chk++;
        if (irq !== m_irq) begin
            n_err++;
            $display("FAIL model_irq t=%0t dut=%b model=%b", $time, irq, m_irq);
        end
        n_chk++;
        if (in_port !== m_in) begin
            n_err++;
            $display("FAIL model_in_port t=%0t port=%h dut=%h model=%h", $time, port_id, in_port, m_in);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = a; out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        port_id = a;
        @(negedge clk);
        read_strobe = 1'b1;
        @(negedge clk);
        d = in_port;
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic pulse_src(input logic [7:0] b);
        @(negedge clk);
        src = b;
        @(negedge clk);
        src = 8'h00;
    endtask

    task automatic pulse_iak();
        @(negedge clk);
        iak = 1'b1;
        @(negedge clk);
        iak = 1'b0;
    endtask

    logic [7:0] d;
    int pick;

    initial begin
        // reset and readback
        cyc(3);
        rst = 1'b1;
        cyc(5);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        rd(A_MASK, d);  chk("reset_mask", d, 8'h00);
        rd(A_CTRL, d);  chk("reset_ctrl", d, 8'h00);
        rd(A_PEND, d);  chk("reset_pending", d, 8'h00);
        wr(A_MASK, 8'hA5);
        rd(A_MASK, d);  chk("mask_rw", d, 8'hA5);
        rd(8'h20, d);   chk("unmapped_read", d, 8'h00);

        // edge capture with exact latency
        wr(A_MASK, 8'hFF);
        wr(A_CTRL, 8'h01);
        @(negedge clk); src = 8'h08;
        @(negedge clk); src = 8'h00;
        @(negedge clk);
        @(negedge clk); chk("irq_before_latency", {7'd0, irq}, 8'h00);
        @(negedge clk); chk("irq_after_latency", {7'd0, irq}, 8'h01);
        rd(A_VEC, d);   chk("vector_src3", d, 8'h83);
        rd(A_PEND, d);  chk("pending_src3", d, 8'h08);

        // priority and handshake
        wr(A_CLEAR, 8'h08);
        cyc(2);
        chk("irq_withdrawn_by_clear", {7'd0, irq}, 8'h00);
        pulse_src(8'h24);
        cyc(4);
        chk("irq_src5_src2", {7'd0, irq}, 8'h01);
        rd(A_VEC, d);   chk("vector_prio", d, 8'h82);
        pulse_iak();
        chk("irq_low_in_service", {7'd0, irq}, 8'h00);
        rd(A_VEC, d);   chk("vector_in_service", d, 8'h82);
        wr(A_CLEAR, 8'h04);
        cyc(2);
        chk("irq_still_low_before_eoi", {7'd0, irq}, 8'h00);
        wr(A_EOI, 8'h5A);
        cyc(1);
        chk("irq_reassert_after_eoi", {7'd0, irq}, 8'h01);
        rd(A_VEC, d);   chk("vector_after_eoi", d, 8'h85);

        // masking and withdrawal
        wr(A_CLEAR, 8'h20);
        cyc(2);
        pulse_src(8'h02);
        cyc(4);
        chk("irq_src1", {7'd0, irq}, 8'h01);
        wr(A_MASK, 8'h00);
        cyc(1);
        chk("irq_masked_drop", {7'd0, irq}, 8'h00);
        rd(A_PEND, d);  chk("pending_kept_masked", d, 8'h02);
        wr(A_MASK, 8'hFF);
        cyc(1);
        chk("irq_mask_restored", {7'd0, irq}, 8'h01);

        // set/clear collision on bit 0
        @(negedge clk); src = 8'h01;
        @(negedge clk); src = 8'h00;
        @(negedge clk); port_id = A_CLEAR; out_port = 8'h01; write_strobe = 1'b1;
        @(negedge clk); write_strobe = 1'b0; port_id = 8'h00;
        rd(A_PEND, d);  chk("collision_set_wins", d, 8'h03);
        wr(A_CLEAR, 8'h03);
        cyc(2);
        chk("irq_after_clear_all", {7'd0, irq}, 8'h00);

        // async reset in SERVICE
        pulse_src(8'h10);
        cyc(4);
        chk("irq_src4", {7'd0, irq}, 8'h01);
        pulse_iak();
        @(negedge clk); src = 8'h80; port_id = A_PEND;
        cyc(5);
        chk("pending_before_reset", in_port, 8'h90);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_irq_async", {7'd0, irq}, 8'h00);
        chk("reset_in_port_async", in_port, 8'h00);
        #2;
        rst = 1'b1;
        port_id = 8'h00;
        wr(A_MASK, 8'hFF);
        wr(A_CTRL, 8'h01);
        cyc(6);
        chk("no_edge_from_held_level", {7'd0, irq}, 8'h00);
        rd(A_PEND, d);  chk("pending_after_reset", d, 8'h00);
        src = 8'h00;

        // randomized traffic checked by the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
            src = src ^ 8'($urandom & $urandom & $urandom & $urandom);
            iak = irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            pick = $urandom_range(0, 7);
            if (pick < 6)       port_id = BASE + 8'(pick);
            else if (pick == 6) port_id = 8'h20;
            else                port_id = 8'($urandom);
            out_port = 8'($urandom);
            if (port_id == A_CTRL) out_port[0] = ($urandom_range(0, 3) != 0);
            write_strobe = ($urandom_range(0, 4) == 0);
            read_strobe  = 1'($urandom);
        end
        @(negedge clk);
        write_strobe = 1'b0; read_strobe = 1'b0; iak = 1'b0; src = 8'h00;
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pb_irq_ctrl.md
Name: pb_irq_ctrl

Overview:
- Interrupt controller and scheduler for the single `interrupt` input of the pacoblaze3 core.
- Collects up to 8 edge-triggered sources and holds them as pending bits. Arbitrates them by fixed priority, drives the core's interrupt line and sequences the assert/acknowledge/end-of-interrupt handshake.
- Firmware reads and configures it through the core's port_id / in_port / out_port I/O space, alongside the outport blocks.

Parameters:
- NSRC, 8, number of interrupt sources (1..8).
- BASE, 8'h10, port_id of register offset 0; registers occupy BASE..BASE+5.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- src  input  NSRC  raw interrupt request lines, asynchronous to clk.
- port_id  input  8  core port_id.
- out_port  input  8  core out_port (write data).
- write_strobe  input  1  core write_strobe.
- read_strobe  input  1  core read_strobe.
- in_port  output  8  read data to core in_port (registered).
- irq  output  1  to core interrupt input.
- iak  input  1  core interrupt_ack, one-cycle pulse.

Behaviour:
- Reset (rst=0, async): sync flops, pending, mask, GIE, in_port and irq all clear to 0; FSM goes to IDLE. Applies mid-handshake: an outstanding irq drops immediately.
- Input conditioning: 2-flop synchronizer per src, then rising-edge detect on the synchronized value. Each detected edge sets pending[i] exactly one cycle later. Latency src→pending is 3 clk.
- Registers (offset from BASE):
  - 0 PENDING (R): pending bits; bits at or above NSRC read 0.
  - 1 MASK (R/W): 1 = source enabled; reset 0x00.
  - 2 CLEAR (W): write 1 to a bit to clear that pending bit; 0 bits have no effect.
  - 3 VECTOR (R): bit7 = any active; bits2:0 = index of highest-priority active source, or 0 when none; other bits 0.
  - 4 CTRL (R/W): bit0 = GIE; other bits read 0.
  - 5 EOI (W): any data; ends service.
- Definitions:
  - active = pending & mask.
  - Priority is fixed: lowest index is highest priority.
- Write timing: a register is written in the cycle where write_strobe=1 and port_id matches; it takes effect the next cycle.
- Pending set/clear conflict: if an edge and a CLEAR bit hit the same pending bit in the same cycle, set wins.
- Read timing: in_port is registered every cycle from the port_id decode, so it is valid 1 cycle after port_id changes. The core holds port_id for 2 cycles, so data is valid when read_strobe is sampled.
- Reads are side-effect free. Unmapped port_id reads 0x00. Writes to read-only offsets are ignored.
- IRQ FSM:
  - IDLE (irq=0): go to ASSERT when GIE=1 and active≠0.
  - ASSERT (irq=1):
    - iak=1 → SERVICE.
    - Otherwise, if active becomes 0 or GIE becomes 0 (firmware masked or cleared) → IDLE, with irq dropped the next cycle.
    - If iak arrives in the same cycle as active falling to 0, iak wins → SERVICE.
  - SERVICE (irq=0): new edges keep accumulating in pending; irq stays low. A write to EOI → IDLE. If active≠0 at that point, IDLE re-asserts irq on the following cycle.
  - An EOI write outside SERVICE is ignored.
  - iak outside ASSERT is ignored.
- The pending bit is not auto-cleared by iak. Firmware reads VECTOR, writes CLEAR, then writes EOI.
- irq is a registered output, glitch-free.

Test Plan:
- Reset then register readback: MASK=0x00, CTRL=0x00, PENDING=0x00; write MASK←0xA5 and read → 0xA5; read unmapped port 0x20 → 0x00.
- Edge capture: GIE=1, MASK=0xFF, pulse src[3] high for 1 clk → PENDING=0x08 after 3 clk; irq=1 one cycle later; VECTOR reads 0x83.
- Priority and handshake: src[5] and src[2] pending, then iak pulse → irq=0, FSM in SERVICE; VECTOR=0x82; write CLEAR←0x04 then EOI → irq re-asserts with VECTOR=0x85.
- Masking and withdrawal: irq asserted for src[1], then write MASK←0x00 before iak → irq drops; PENDING still 0x02; restore MASK → irq returns.
- Set/clear collision: src[0] edge lands in the same cycle as CLEAR←0x01 → PENDING bit0 remains 1.
- Async reset mid-SERVICE: drive rst=0 for half a cycle → irq=0 and PENDING=0 immediately; after release, a level held high on src generates no edge and irq stays 0.
